// File: rtl/ysyx_24100012_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: request codes,
// CSR addresses, cause values, mstatus bit positions and FSM encodings.
package ysyx_24100012_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    TT_NONE  = 2'b00,
    TT_ECALL = 2'b01,
    TT_MRET  = 2'b10,
    TT_RSVD  = 2'b11
  } trap_type_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL_M   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_IRQ_EXT_M = 32'h8000_000B;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_MST,
    S_W_MRET,
    S_REDIR
  } state_e;

  // TRAP covers both ecall and external interrupt entry.
  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } kind_e;

endpackage

// File: rtl/ysyx_24100012_mstatus_upd.sv
// Computes the new mstatus value for trap entry (stack MIE into MPIE, enter M)
// or for mret (pop MPIE back into MIE, drop to U).
module ysyx_24100012_mstatus_upd
  import ysyx_24100012_trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_mst,
  input  logic                  kind,
  output logic [DATA_WIDTH-1:0] new_mst
);

  always_comb begin
    new_mst = old_mst;
    if (kind == KIND_MRET) begin
      new_mst[MST_MIE]               = old_mst[MST_MPIE];
      new_mst[MST_MPIE]              = 1'b1;
      new_mst[MST_MPP_HI:MST_MPP_LO] = 2'b00;
    end else begin
      new_mst[MST_MPIE]              = old_mst[MST_MIE];
      new_mst[MST_MIE]               = 1'b0;
      new_mst[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    end
  end

endmodule

// File: rtl/ysyx_24100012_trap_ctrl.sv
// Machine-mode trap controller: sequences the mepc/mcause/mstatus writes for
// ecall and external interrupts, the mstatus write for mret, then redirects fetch.
module ysyx_24100012_trap_ctrl
  import ysyx_24100012_trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_valid,
  input  logic [1:0]            trap_type,
  input  logic [ADDR_WIDTH-1:0] trap_pc,
  output logic                  trap_ready,
  input  logic                  irq_pending,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  irq_ack,
  output logic [11:0]           csr_ridx,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_wen,
  output logic [11:0]           csr_widx,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy
);

  state_e                state;
  kind_e                 kind_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] cause_q;
  logic [DATA_WIDTH-1:0] mst_new;
  logic                  is_idle;
  logic                  mie;
  logic                  irq_take;

  assign is_idle    = (state == S_IDLE);
  assign trap_ready = is_idle;
  assign busy       = !is_idle;

  // In IDLE the read port points at mstatus, so rdata carries the live MIE bit.
  assign mie      = csr_rdata[MST_MIE];
  assign irq_take = is_idle && !trap_valid && irq_pending && mie;
  assign irq_ack  = irq_take && rst;

  ysyx_24100012_mstatus_upd #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mstatus_upd (
    .old_mst(csr_rdata),
    .kind   (kind_q),
    .new_mst(mst_new)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      kind_q  <= KIND_TRAP;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trap_valid) begin
            case (trap_type)
              TT_ECALL: begin
                pc_q    <= trap_pc;
                cause_q <= DATA_WIDTH'(CAUSE_ECALL_M);
                kind_q  <= KIND_TRAP;
                state   <= S_W_EPC;
              end
              TT_MRET: begin
                kind_q <= KIND_MRET;
                state  <= S_W_MRET;
              end
              default: ;
            endcase
          end else if (irq_take) begin
            pc_q    <= next_pc;
            cause_q <= DATA_WIDTH'(CAUSE_IRQ_EXT_M);
            kind_q  <= KIND_TRAP;
            state   <= S_W_EPC;
          end
        end
        S_W_EPC:   state <= S_W_CAUSE;
        S_W_CAUSE: state <= S_W_MST;
        S_W_MST:   state <= S_REDIR;
        S_W_MRET:  state <= S_REDIR;
        S_REDIR:   state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Read index and write port are pure state decode; rdata feeds straight through.
  always_comb begin
    csr_ridx       = CSR_MSTATUS;
    csr_wen        = 1'b0;
    csr_widx       = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      S_W_EPC: begin
        csr_wen   = 1'b1;
        csr_widx  = CSR_MEPC;
        csr_wdata = DATA_WIDTH'(pc_q);
      end
      S_W_CAUSE: begin
        csr_wen   = 1'b1;
        csr_widx  = CSR_MCAUSE;
        csr_wdata = cause_q;
      end
      S_W_MST, S_W_MRET: begin
        csr_wen   = 1'b1;
        csr_widx  = CSR_MSTATUS;
        csr_wdata = mst_new;
      end
      S_REDIR: begin
        csr_ridx       = (kind_q == KIND_MRET) ? CSR_MEPC : CSR_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[ADDR_WIDTH-1:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24100012_trap_ctrl.sv
// Directed bench for the trap controller: a cycle-by-cycle vector table with
// hand-computed CSR traffic, plus reset and irq-masking sequences.
module tb_ysyx_24100012_trap_ctrl;

  typedef struct {
    logic        tv;
    logic [1:0]  tt;
    logic [31:0] tpc;
    logic        irq;
    logic [31:0] npc;
    logic [31:0] rdata;
    logic        e_ready;
    logic        e_busy;
    logic        e_ack;
    logic        chk_ridx;
    logic [11:0] e_ridx;
    logic        e_wen;
    logic [11:0] e_widx;
    logic [31:0] e_wdata;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        trap_valid;
  logic [1:0]  trap_type;
  logic [31:0] trap_pc;
  logic        trap_ready;
  logic        irq_pending;
  logic [31:0] next_pc;
  logic        irq_ack;
  logic [11:0] csr_ridx;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_widx;
  logic [31:0] csr_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int tests_run;
  int tests_failed;
  vec_t vecs[34];

  ysyx_24100012_trap_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .trap_valid    (trap_valid),
    .trap_type     (trap_type),
    .trap_pc       (trap_pc),
    .trap_ready    (trap_ready),
    .irq_pending   (irq_pending),
    .next_pc       (next_pc),
    .irq_ack       (irq_ack),
    .csr_ridx      (csr_ridx),
    .csr_rdata     (csr_rdata),
    .csr_wen       (csr_wen),
    .csr_widx      (csr_widx),
    .csr_wdata     (csr_wdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic tv, input logic [1:0] tt, input logic [31:0] tpc,
    input logic irq, input logic [31:0] npc, input logic [31:0] rdata,
    input logic e_ready, input logic e_busy, input logic e_ack,
    input logic chk_ridx, input logic [11:0] e_ridx,
    input logic e_wen, input logic [11:0] e_widx, input logic [31:0] e_wdata,
    input logic e_rv, input logic [31:0] e_rpc);
    vec_t v;
    v.tv = tv; v.tt = tt; v.tpc = tpc; v.irq = irq; v.npc = npc; v.rdata = rdata;
    v.e_ready = e_ready; v.e_busy = e_busy; v.e_ack = e_ack;
    v.chk_ridx = chk_ridx; v.e_ridx = e_ridx;
    v.e_wen = e_wen; v.e_widx = e_widx; v.e_wdata = e_wdata;
    v.e_rv = e_rv; v.e_rpc = e_rpc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    trap_valid  = v.tv;
    trap_type   = v.tt;
    trap_pc     = v.tpc;
    irq_pending = v.irq;
    next_pc     = v.npc;
    csr_rdata   = v.rdata;
  endtask

  // Drive one cycle's inputs just after the falling edge, then compare the
  // combinational outputs well before the next rising edge.
  task automatic runVector(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput({tag, ".ready"}, 32'(trap_ready), 32'(v.e_ready));
    checkOutput({tag, ".busy"},  32'(busy),       32'(v.e_busy));
    checkOutput({tag, ".ack"},   32'(irq_ack),    32'(v.e_ack));
    checkOutput({tag, ".wen"},   32'(csr_wen),    32'(v.e_wen));
    checkOutput({tag, ".rv"},    32'(redirect_valid), 32'(v.e_rv));
    if (v.chk_ridx) checkOutput({tag, ".ridx"}, 32'(csr_ridx), 32'(v.e_ridx));
    if (v.e_wen) begin
      checkOutput({tag, ".widx"},  32'(csr_widx), 32'(v.e_widx));
      checkOutput({tag, ".wdata"}, csr_wdata,     v.e_wdata);
    end
    if (v.e_rv) checkOutput({tag, ".rpc"}, redirect_pc, v.e_rpc);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".ready"}, 32'(trap_ready), 32'd1);
    checkOutput({tag, ".busy"},  32'(busy),       32'd0);
    checkOutput({tag, ".wen"},   32'(csr_wen),    32'd0);
    checkOutput({tag, ".rv"},    32'(redirect_valid), 32'd0);
    checkOutput({tag, ".ack"},   32'(irq_ack),    32'd0);
    checkOutput({tag, ".rpc"},   redirect_pc,     32'd0);
    checkOutput({tag, ".wdata"}, csr_wdata,       32'd0);
    checkOutput({tag, ".widx"},  32'(csr_widx),   32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // ecall: mepc, mcause, mstatus 0x8 -> 0x1880, redirect to mtvec at cycle 4
    vecs[0]  = mk(1, 2'b01, 32'h8000_0100, 0, 0, 32'h0000_0008, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 2'b10, 32'hDEAD_0000, 1, 0, 32'h0000_0008, 0, 1, 0, 0, 0, 1, 12'h341, 32'h8000_0100, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 12'h342, 32'h0000_000B, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0000_0008, 0, 1, 0, 1, 12'h300, 1, 12'h300, 32'h0000_1880, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 32'h8000_1003, 0, 1, 0, 1, 12'h305, 0, 0, 0, 1, 32'h8000_1000);
    // mret: mstatus 0x1880 -> 0x88, redirect to mepc at cycle 2
    vecs[5]  = mk(1, 2'b10, 0, 0, 0, 32'h0000_1880, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 32'h0000_1880, 0, 1, 0, 1, 12'h300, 1, 12'h300, 32'h0000_0088, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 32'h8000_0104, 0, 1, 0, 1, 12'h341, 0, 0, 0, 1, 32'h8000_0104);
    // external interrupt with MIE set
    vecs[8]  = mk(0, 0, 0, 1, 32'h8000_0200, 32'h0000_0008, 1, 0, 1, 1, 12'h300, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 32'h8000_0200, 0, 0, 1, 0, 0, 0, 1, 12'h341, 32'h8000_0200, 0, 0);
    vecs[10] = mk(0, 0, 0, 1, 32'h8000_0200, 0, 0, 1, 0, 0, 0, 1, 12'h342, 32'h8000_000B, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 32'h8000_0200, 32'h0000_0008, 0, 1, 0, 1, 12'h300, 1, 12'h300, 32'h0000_1880, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 32'h8000_0200, 32'h8000_1003, 0, 1, 0, 1, 12'h305, 0, 0, 0, 1, 32'h8000_1000);
    // irq masked, then none/reserved requests leave the FSM idle
    vecs[13] = mk(0, 0, 0, 1, 32'h8000_0200, 32'h0000_1880, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 2'b00, 32'h1234_0000, 0, 0, 0, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0);
    vecs[15] = mk(1, 2'b11, 32'h1234_0004, 0, 0, 0, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0);
    // mret with MPIE clear and unrelated high bits preserved; misaligned mepc
    vecs[17] = mk(1, 2'b10, 0, 0, 0, 0, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 32'hF000_1800, 0, 1, 0, 1, 12'h300, 1, 12'h300, 32'hF000_0080, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 32'h1234_5677, 0, 1, 0, 1, 12'h341, 0, 0, 0, 1, 32'h1234_5674);
    // ecall and eligible irq together: request wins, irq waits for mret
    vecs[20] = mk(1, 2'b01, 32'h0000_ABC4, 1, 32'h0000_ABC8, 32'hFFFF_FFFF, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 1, 32'h0000_ABC8, 0, 0, 1, 0, 0, 0, 1, 12'h341, 32'h0000_ABC4, 0, 0);
    vecs[22] = mk(0, 0, 0, 1, 32'h0000_ABC8, 0, 0, 1, 0, 0, 0, 1, 12'h342, 32'h0000_000B, 0, 0);
    vecs[23] = mk(0, 0, 0, 1, 32'h0000_ABC8, 32'hFFFF_E7FF, 0, 1, 0, 1, 12'h300, 1, 12'h300, 32'hFFFF_FFF7, 0, 0);
    vecs[24] = mk(1, 2'b10, 0, 1, 32'h0000_ABC8, 32'h8000_1000, 0, 1, 0, 1, 12'h305, 0, 0, 0, 1, 32'h8000_1000);
    vecs[25] = mk(1, 2'b10, 0, 1, 32'h0000_ABC8, 32'hFFFF_FFF7, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0);
    vecs[26] = mk(0, 0, 0, 1, 32'h0000_ABC8, 32'hFFFF_FFF7, 0, 1, 0, 1, 12'h300, 1, 12'h300, 32'hFFFF_E7FF, 0, 0);
    vecs[27] = mk(0, 0, 0, 1, 32'h0000_ABC8, 32'h0000_ABC4, 0, 1, 0, 1, 12'h341, 0, 0, 0, 1, 32'h0000_ABC4);
    vecs[28] = mk(0, 0, 0, 1, 32'h0000_ABC8, 32'hFFFF_E7FF, 1, 0, 1, 1, 12'h300, 0, 0, 0, 0, 0);
    vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 12'h341, 32'h0000_ABC8, 0, 0);
    vecs[30] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 12'h342, 32'h8000_000B, 0, 0);
    vecs[31] = mk(0, 0, 0, 0, 0, 32'h0000_0008, 0, 1, 0, 1, 12'h300, 1, 12'h300, 32'h0000_1880, 0, 0);
    vecs[32] = mk(0, 0, 0, 0, 0, 32'h8000_1003, 0, 1, 0, 1, 12'h305, 0, 0, 0, 1, 32'h8000_1000);
    vecs[33] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0);

    // Reset with an eligible irq on the inputs: irq_ack must stay low.
    rst         = 1'b0;
    trap_valid  = 1'b0;
    trap_type   = 2'b00;
    trap_pc     = '0;
    irq_pending = 1'b1;
    next_pc     = 32'h8000_0400;
    csr_rdata   = 32'h0000_0008;
    #2;
    checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    irq_pending = 1'b0;
    rst         = 1'b1;

    for (int i = 0; i < 34; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Interrupt pending with MIE clear: nothing accepted, nothing written.
    for (int i = 0; i < 10; i++) begin
      runVector(mk(0, 0, 0, 1, 32'h8000_0300, 32'h0000_0000, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0),
                $sformatf("masked%0d", i));
    end

    // Asynchronous reset while in W_CAUSE abandons the sequence at once.
    runVector(mk(1, 2'b01, 32'h8000_0500, 0, 0, 32'h0000_0008, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0), "rstseq.acc");
    runVector(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 12'h341, 32'h8000_0500, 0, 0), "rstseq.epc");
    @(negedge clk);
    applyStimulus(mk(0, 0, 0, 1, 32'h8000_0600, 32'h0000_0008, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("rstseq.cause_wen", 32'(csr_wen), 32'd1);
    checkOutput("rstseq.cause_widx", 32'(csr_widx), 32'h342);
    rst = 1'b0;
    #1;
    checkResetOutputs("rstseq.async");
    @(posedge clk);
    #1;
    checkResetOutputs("rstseq.held");
    @(negedge clk);
    irq_pending = 1'b0;
    rst         = 1'b1;
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0), "rstseq.idle");
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 12'h300, 0, 0, 0, 0, 0), "rstseq.stay");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ysyx_24100012_trap_ctrl.md
YSYX_24100012_TRAP_CTRL -- requirements
Module: ysyx_24100012_trap_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, CSR data width.
REQ-002 Parameter ADDR_WIDTH, default 32, PC width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 trap_valid  input  1  request from EXU.
REQ-006 trap_type  input  2  00 none, 01 ecall, 10 mret, 11 reserved.
REQ-007 trap_pc  input  ADDR_WIDTH  PC of the requesting instruction.
REQ-008 trap_ready  output  1  high only in IDLE.
REQ-009 irq_pending  input  1  level machine-external interrupt.
REQ-010 next_pc  input  ADDR_WIDTH  PC saved as mepc on an interrupt.
REQ-011 irq_ack  output  1  one-cycle pulse when an interrupt is accepted.
REQ-012 csr_ridx  output  12  CSR read index; combinational from state.
REQ-013 csr_rdata  input  DATA_WIDTH  combinational CSR read data for csr_ridx.
REQ-014 csr_wen, csr_widx[11:0], csr_wdata[DATA_WIDTH]  output  CSR write port.
REQ-015 redirect_valid  output  1, plus redirect_pc  output  ADDR_WIDTH  fetch redirect.
REQ-016 busy  output  1  high whenever state != IDLE; front end stalls on it.

Function
REQ-017 FSM states SHALL be IDLE, W_EPC, W_CAUSE, W_MST, W_MRET, REDIR.
REQ-018 IDLE: csr_ridx=0x300; MIE = csr_rdata[3].
REQ-019 Handshake trap_valid&trap_ready with type 01 SHALL capture trap_pc, cause=0x0000000B, kind=TRAP, and go to W_EPC.
REQ-020 Type 10 SHALL capture kind=MRET and go to W_MRET.
REQ-021 Types 00/11 SHALL complete the handshake with no state change and no CSR write.
REQ-022 With trap_valid=0, irq_pending=1 and MIE=1 in IDLE: capture next_pc, cause=0x8000000B, kind=TRAP, irq_ack=1 that cycle, go to W_EPC.
REQ-023 trap_valid=1 together with an eligible irq: the request wins; irq_ack stays 0; irq is reconsidered on the next IDLE cycle.
REQ-024 W_EPC: csr_wen=1, widx=0x341, wdata=captured pc; next state W_CAUSE.
REQ-025 W_CAUSE: csr_wen=1, widx=0x342, wdata=captured cause; next state W_MST.
REQ-026 W_MST: ridx=0x300; write 0x300 with rdata, except bit7=rdata[3], bit3=0, bits12:11=2'b11; next state REDIR.
REQ-027 W_MRET: ridx=0x300; write 0x300 with rdata, except bit3=rdata[7], bit7=1, bits12:11=2'b00; next state REDIR.
REQ-028 REDIR: ridx=0x305 for TRAP or 0x341 for MRET; redirect_valid=1; redirect_pc={rdata[31:2],2'b00}; csr_wen=0; next state IDLE.
REQ-029 Latency: ecall/irq redirect 4 cycles after accept; mret redirect 2 cycles after accept.
REQ-030 Inputs other than csr_rdata SHALL be ignored outside IDLE; captured values SHALL stay stable until IDLE.
REQ-031 csr_wen SHALL be 0 in IDLE and REDIR; at most one CSR write per cycle.
REQ-032 Back-to-back: a request held high during REDIR SHALL be accepted on the following IDLE cycle.

Reset
REQ-033 rst low SHALL force IDLE immediately, asynchronously, from any state; any remaining sequence writes are abandoned.
REQ-034 Output values during reset: trap_ready=1, busy=0, csr_wen=0, redirect_valid=0, irq_ack=0, redirect_pc=0, csr_wdata=0, csr_widx=0.
REQ-035 Captured pc and cause registers SHALL reset to 0.

Structure
REQ-036 Shared package: trap_type codes, CSR addresses 0x300/0x305/0x341/0x342, cause constants, FSM state enum, and the mstatus bit positions 3, 7 and 12:11.
REQ-037 One sub-module, ysyx_24100012_mstatus_upd: combinational, in=old mstatus and kind, out=new mstatus (REQ-026/027).
REQ-038 The CSR file is external; this block only drives the read index and the write port.

Verification
REQ-039 ecall, trap_pc=0x80000100, mtvec=0x80001003, mstatus=0x8: writes mepc=0x80000100, then mcause=0xB, then mstatus=0x1880; redirect_pc=0x80001000 at cycle 4.
REQ-040 mret, mepc=0x80000104, mstatus=0x1880: mstatus write 0x88; redirect_pc=0x80000104 at cycle 2.
REQ-041 irq_pending=1 with mstatus=0x8, next_pc=0x80000200: irq_ack pulses once; mcause write 0x8000000B; mepc write 0x80000200.
REQ-042 irq_pending=1 with mstatus=0x0: no accept and no writes for 10 cycles.
REQ-043 ecall and irq in the same cycle: ecall sequence runs; irq accepted in the IDLE cycle after REDIR (mstatus MIE restored via mret first).
REQ-044 rst low in W_CAUSE: no further csr_wen; IDLE and trap_ready=1 are observed before the next clock edge.
